// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle execution unit for the multi-cycle core.
// Logic/arithmetic ops complete in one cycle; shifts move one bit per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready high only when idle)
//   alu_control         4-bit operation code (1010-1111 execute as ADD)
//   op_a, op_b          operands; for shifts op_b[SW-1:0] is the amount
//   out_valid, out_ready  result handshake (out_valid high only when done)
//   result, zero        registered result and (result == 0)
module alu_seq_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int unsigned SW = $clog2(XLEN);

   localparam logic [3:0] OpAdd  = 4'b0000;
   localparam logic [3:0] OpSub  = 4'b0001;
   localparam logic [3:0] OpAnd  = 4'b0010;
   localparam logic [3:0] OpOr   = 4'b0011;
   localparam logic [3:0] OpXor  = 4'b0100;
   localparam logic [3:0] OpSll  = 4'b0101;
   localparam logic [3:0] OpSrl  = 4'b0110;
   localparam logic [3:0] OpSra  = 4'b0111;
   localparam logic [3:0] OpSlt  = 4'b1000;
   localparam logic [3:0] OpSltu = 4'b1001;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q, state_d;
   logic [3:0]      op_q, op_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [SW-1:0]   count_q, count_d;

   logic [XLEN-1:0] single_res;
   logic            is_shift;
   logic [SW-1:0]   shamt;

   assign shamt    = op_b[SW-1:0];
   assign is_shift = (alu_control == OpSll) || (alu_control == OpSrl) ||
                     (alu_control == OpSra);

   // Single-cycle result, computed straight from the request inputs.
   always_comb begin
      single_res = op_a + op_b;
      case (alu_control)
         OpSub:   single_res = op_a - op_b;
         OpAnd:   single_res = op_a & op_b;
         OpOr:    single_res = op_a | op_b;
         OpXor:   single_res = op_a ^ op_b;
         OpSlt:   single_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OpSltu:  single_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: single_res = op_a + op_b;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      result_d = result_q;
      count_d  = count_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               op_d = alu_control;
               if (is_shift) begin
                  result_d = op_a;
                  if (shamt == '0) begin
                     state_d = StDone;
                  end else begin
                     count_d = shamt;
                     state_d = StShift;
                  end
               end else begin
                  result_d = single_res;
                  state_d  = StDone;
               end
            end
         end
         StShift: begin
            case (op_q)
               OpSll:   result_d = {result_q[XLEN-2:0], 1'b0};
               OpSrl:   result_d = {1'b0, result_q[XLEN-1:1]};
               default: result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
            endcase
            count_d = count_q - 1'b1;
            if (count_q == SW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= OpAdd;
         result_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         result_q <= result_d;
         count_q  <= count_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alu_control = 4'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_res;

   always #5 clk = ~clk;

   alu_seq_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic. edges = clock edges after the accept
   // edge before out_valid shows (a shift by n walks n single-bit steps).
   function automatic void model(input logic [3:0] code, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r,
                                 output int edges);
      int n;
      n     = int'(b % 32);
      edges = 0;
      case (code)
         4'd1: r = a - b;
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: begin r = a << n; edges = n; end
         4'd6: begin r = a >> n; edges = n; end
         4'd7: begin r = 32'($signed(a) >>> n); edges = n; end
         4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9: r = (a < b) ? 32'd1 : 32'd0;
         default: r = a + b;
      endcase
   endfunction

   // One transaction; hold = cycles of out_ready=0 after out_valid rises,
   // during which a competing request is presented.
   task automatic issue(input string tag, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int          exp_edges;
      int          edges;
      model(code, a, b, exp, exp_edges);
      edges = 0;
      while (!in_ready && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      alu_control = code;
      op_a        = a;
      op_b        = b;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      @(posedge clk); #1;
      // Scramble inputs: the captured request must be used.
      in_valid    = 1'b0;
      alu_control = 4'($urandom);
      op_a        = $urandom;
      op_b        = $urandom;
      edges = 0;
      while (!out_valid && edges < 64) begin
         @(posedge clk); #1;
         edges++;
      end
      check({tag, ".latency"}, 32'(edges), 32'(exp_edges));
      check({tag, ".result"}, result, exp);
      check({tag, ".zero"}, 32'(zero), 32'(exp == 32'd0));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         op_a     = ~exp;
         op_b     = 32'h1234_5678;
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
         check({tag, ".hold_result"}, result, exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
      last_res = exp;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".result"}, result, 32'd0);
      check({tag, ".zero"}, 32'(zero), 32'd1);
   endtask

   initial begin
      logic [31:0] r;
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      issue("warm", 4'd0, 32'd10, 32'd20, 0);

      // Reset asserted mid-simulation, away from an edge.
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("rst");
      @(posedge clk); #1;
      check_reset_outputs("rst_held");
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      issue("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 0);
      check("add_ovf.const", result, 32'h8000_0000);

      // Code sweep on complementary patterns.
      for (int c = 0; c < 16; c++) begin
         issue($sformatf("sweep%0d", c), 4'(c), 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0);
         r = last_res;
         case (c)
            1:  check("sweep.sub", result, 32'hE1E1_E1E1);
            2:  check("sweep.and", result, 32'd0);
            3:  check("sweep.or", result, 32'hFFFF_FFFF);
            4:  check("sweep.xor", result, 32'hFFFF_FFFF);
            8:  check("sweep.slt", result, 32'd1);
            9:  check("sweep.sltu", result, 32'd0);
            15: check("sweep.c15", result, 32'hFFFF_FFFF);
            default: check("sweep.model", result, r);
         endcase
      end

      issue("sra31", 4'd7, 32'h8000_0000, 32'd31, 0);
      check("sra31.const", result, 32'hFFFF_FFFF);
      issue("srl31", 4'd6, 32'h8000_0000, 32'd31, 0);
      check("srl31.const", result, 32'd1);
      issue("sll0", 4'd5, 32'd1, 32'h20, 0);
      check("sll0.const", result, 32'd1);

      issue("bp", 4'd4, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5);
      issue("bp_shift", 4'd7, 32'h9000_0001, 32'd3, 2);

      for (int k = 0; k < 60; k++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (k % 7 == 0) rb = ra;
         if (k % 5 == 0) rb = rb & 32'h0000_000F;
         issue($sformatf("rnd%0d", k), 4'($urandom_range(0, 15)), ra, rb,
               int'($urandom_range(0, 3)));
      end

      // Reset during a serial shift.
      while (!in_ready) begin @(posedge clk); #1; end
      alu_control = 4'd5;
      op_a        = 32'h0000_0ABC;
      op_b        = 32'd20;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.result", result, 32'd0);
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #3 rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid) check("midrst.no_result", 32'(out_valid), 32'd0);
      end
      issue("post_rst", 4'd0, 32'd2, 32'd3, 0);
      check("post_rst.const", result, 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
